// File: rtl/if_stage.sv
// if_stage: instruction fetch with one outstanding SRAM request, a one-entry output slot and a skid buffer
// Optional IF_BPU_EN: when defined, the branch predictor steers the next fetch PC.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_allow_in,
  output logic        if_to_id_valid,
  output logic [64:0] if_to_id_bus,
  input  logic [32:0] id_to_if_bus,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] bp_pc,
  input  logic        bp_taken,
  input  logic [31:0] bp_target
);
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [31:0] r_fetch_pc;
  logic [1:0]  r_state;
  logic [31:0] r_req_pc;
  logic        r_req_pred;
  logic        r_drop;
  logic        r_valid;
  logic [64:0] r_data;
  logic [64:0] r_skid;

  logic        w_redirect;
  logic [31:0] w_br_target;
  logic        w_consume;
  logic        w_is_req;
  logic        w_is_wait;
  logic        w_is_hold;
  logic        w_accept;
  logic        w_resp;
  logic        w_fill;
  logic        w_slot_free;
  logic        w_pred_taken;
  logic [31:0] w_next_pc;
  logic [64:0] w_resp_word;
  logic [1:0]  w_state_n;
  logic        w_drop_n;
  logic        w_valid_n;
  logic [64:0] w_data_n;
  logic [31:0] w_fetch_pc_n;

  assign w_redirect  = id_to_if_bus[32];
  assign w_br_target = id_to_if_bus[31:0];
  assign w_consume   = r_valid && id_allow_in;
  assign w_is_req    = r_state == S_REQ;
  assign w_is_wait   = r_state == S_WAIT;
  assign w_is_hold   = r_state == S_HOLD;
  assign w_accept    = w_is_req && inst_sram_addr_ok;
  assign w_resp      = w_is_wait && inst_sram_data_ok;
  assign w_fill      = w_resp && !r_drop && !w_redirect;
  assign w_slot_free = !r_valid || w_consume;
  assign w_resp_word = {r_req_pred, r_req_pc, inst_sram_rdata};

`ifdef IF_BPU_EN
  assign w_pred_taken = bp_taken;
  assign w_next_pc    = bp_taken ? bp_target : r_fetch_pc + 32'd4;
  assign bp_pc        = r_fetch_pc;
`else
  logic w_unused;
  assign w_unused     = ^{bp_taken, bp_target};
  assign w_pred_taken = 1'b0;
  assign w_next_pc    = r_fetch_pc + 32'd4;
  assign bp_pc        = 32'd0;
`endif

  assign if_to_id_valid = r_valid;
  assign if_to_id_bus   = r_data;
  assign inst_sram_req  = reset && w_is_req;
  assign inst_sram_addr = r_fetch_pc;

  // Next-state: a redirect flushes the slot and marks any in-flight request stale
  always_comb begin
    w_state_n    = w_is_req  ? (w_accept ? S_WAIT : S_REQ)
                 : w_is_wait ? (!inst_sram_data_ok ? S_WAIT : (w_fill && !w_slot_free) ? S_HOLD : S_REQ)
                 : w_is_hold ? ((w_redirect || w_consume) ? S_REQ : S_HOLD)
                 : S_REQ;
    w_drop_n     = w_resp ? 1'b0 : (w_redirect && (w_accept || w_is_wait)) ? 1'b1 : r_drop;
    w_valid_n    = w_redirect ? 1'b0
                 : ((w_fill && w_slot_free) || (w_is_hold && w_consume)) ? 1'b1
                 : w_consume ? 1'b0 : r_valid;
    w_data_n     = (w_fill && w_slot_free) ? w_resp_word
                 : (w_is_hold && w_consume) ? r_skid : r_data;
    w_fetch_pc_n = w_redirect ? w_br_target : w_accept ? w_next_pc : r_fetch_pc;
  end

  // State registers, cleared asynchronously while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_state    <= S_REQ;
      r_req_pc   <= 32'd0;
      r_req_pred <= 1'b0;
      r_drop     <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= 65'd0;
      r_skid     <= 65'd0;
    end else begin
      r_fetch_pc <= w_fetch_pc_n;
      r_state    <= w_state_n;
      r_drop     <= w_drop_n;
      r_valid    <= w_valid_n;
      r_data     <= w_data_n;
      if (w_accept) begin
        r_req_pc   <= r_fetch_pc;
        r_req_pred <= w_pred_taken;
      end
      if (w_fill && !w_slot_free) r_skid <= w_resp_word;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: random and directed stimulus against a queue-based fetch model
module tb_if_stage;
`ifdef IF_BPU_EN
  localparam bit BPU = 1'b1;
`else
  localparam bit BPU = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_allow_in = 1'b0;
  logic        if_to_id_valid;
  logic [64:0] if_to_id_bus;
  logic [32:0] id_to_if_bus = 33'd0;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'd0;
  logic [31:0] bp_pc;
  logic        bp_taken = 1'b0;
  logic [31:0] bp_target = 32'd0;

  if_stage dut (
    .clk(clk), .reset(reset), .id_allow_in(id_allow_in),
    .if_to_id_valid(if_to_id_valid), .if_to_id_bus(if_to_id_bus),
    .id_to_if_bus(id_to_if_bus), .inst_sram_req(inst_sram_req),
    .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .bp_pc(bp_pc), .bp_taken(bp_taken), .bp_target(bp_target)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [64:0] q[$];
  bit          m_out, m_stale, m_pend_pred;
  logic [31:0] m_pc, m_pend_pc;
  logic [31:0] acc_log[$];
  logic [64:0] bus_log[$];
  bit          g_rnd = 1'b0, g_dok = 1'b1, g_allow = 1'b1, g_red = 1'b0;
  logic [31:0] g_tgt = 32'd0, g_bp_at = 32'd0, g_bp_tgt = 32'd0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3c5a9e11;
  endfunction

  task automatic chk(input string n, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_out = 1'b0;
    m_stale = 1'b0;
    m_pend_pred = 1'b0;
    m_pend_pc = 32'd0;
    m_pc = RST_PC;
    acc_log.delete();
    bus_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    id_allow_in = 1'b0;
    id_to_if_bus = 33'd0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata = $urandom();
    bp_taken = 1'b0;
    repeat (2) @(posedge clk);
    inst_sram_data_ok = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step();
    bit a, d, al, r, bt, pt, req, acc, cons;
    logic [31:0] tg, bg, nxt;
    @(negedge clk);
    req = !m_out && q.size() < 2;
    chk("valid", 65'(if_to_id_valid), 65'(q.size() != 0));
    if (q.size() != 0) chk("bus", if_to_id_bus, q[0]);
    chk("req", 65'(inst_sram_req), 65'(req));
    if (req) chk("addr", 65'(inst_sram_addr), 65'(m_pc));
    chk("bp_pc", 65'(bp_pc), BPU ? 65'(m_pc) : 65'd0);
    if (g_rnd) begin
      a = ($urandom() % 3) != 0;
      d = ($urandom() % 2) != 0;
      al = ($urandom() % 4) != 0;
      r = ($urandom() % 16) == 0;
      tg = $urandom() & 32'hfffffffc;
      bt = ($urandom() % 4) == 0;
      bg = $urandom() & 32'hfffffffc;
    end else begin
      a = 1'b1;
      d = g_dok;
      al = g_allow;
      r = g_red;
      tg = g_tgt;
      bt = (m_pc == g_bp_at);
      bg = g_bp_tgt;
    end
    d = d && m_out;
    inst_sram_addr_ok = a;
    inst_sram_data_ok = d;
    inst_sram_rdata = d ? mem(m_pend_pc) : $urandom();
    id_allow_in = al;
    id_to_if_bus = {r, tg};
    bp_taken = bt;
    bp_target = bg;
    if (inst_sram_req && a) acc_log.push_back(inst_sram_addr);
    if (if_to_id_valid && al) bus_log.push_back(if_to_id_bus);
    cons = q.size() != 0 && al;
    acc = req && a;
    pt = BPU && bt;
    nxt = pt ? bg : m_pc + 32'd4;
    if (r) begin
      q.delete();
      if (acc) begin
        m_out = 1'b1;
        m_stale = 1'b1;
      end else if (d) begin
        m_out = 1'b0;
        m_stale = 1'b0;
      end else if (m_out) m_stale = 1'b1;
      m_pc = tg;
    end else begin
      if (cons) void'(q.pop_front());
      if (d) begin
        m_out = 1'b0;
        if (!m_stale) q.push_back({m_pend_pred, m_pend_pc, mem(m_pend_pc)});
        m_stale = 1'b0;
      end
      if (acc) begin
        m_out = 1'b1;
        m_stale = 1'b0;
        m_pend_pc = m_pc;
        m_pend_pred = pt;
        m_pc = nxt;
      end
    end
  endtask

  task automatic run_until_acc(input int n);
    for (int i = 0; i < 40 && acc_log.size() < n; i++) step();
    chk("acc_timeout", 65'(acc_log.size() >= n), 65'd1);
  endtask

  task automatic async_reset_check();
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", 65'(if_to_id_valid), 65'd0);
    chk("rst_bus", if_to_id_bus, 65'd0);
    chk("rst_req", 65'(inst_sram_req), 65'd0);
  endtask

  initial begin
    int n;
    do_reset();
    // straight-line fetch with a predicted branch at 1c000010
    g_bp_at = 32'h1c000010;
    g_bp_tgt = 32'h1c000040;
    repeat (16) step();
    chk("seq_acc0", 65'(acc_log[0]), 65'h1c000000);
    chk("seq_acc1", 65'(acc_log[1]), 65'h1c000004);
    chk("seq_acc2", 65'(acc_log[2]), 65'h1c000008);
    chk("seq_acc5", 65'(acc_log[5]), BPU ? 65'h1c000040 : 65'h1c000014);
    chk("seq_bus0", bus_log[0], {1'b0, 32'h1c000000, mem(32'h1c000000)});
    chk("seq_pc1", 65'(bus_log[1][63:32]), 65'h1c000004);
    chk("seq_pc2", 65'(bus_log[2][63:32]), 65'h1c000008);
    chk("seq_pred", bus_log[4], {BPU, 32'h1c000010, mem(32'h1c000010)});
    g_bp_at = 32'd0;
    // ID stall: slot plus skid fill, requests pause
    do_reset();
    g_allow = 1'b0;
    repeat (7) step();
    chk("stall_pc", 65'(if_to_id_bus[63:32]), 65'h1c000000);
    chk("stall_nacc", 65'(acc_log.size()), 65'd2);
    chk("stall_noreq", 65'(inst_sram_req), 65'd0);
    g_allow = 1'b1;
    repeat (10) step();
    chk("stall_pc0", 65'(bus_log[0][63:32]), 65'h1c000000);
    chk("stall_pc1", 65'(bus_log[1][63:32]), 65'h1c000004);
    chk("stall_pc2", 65'(bus_log[2][63:32]), 65'h1c000008);
    // redirect while waiting for 1c000008
    do_reset();
    run_until_acc(3);
    g_dok = 1'b0;
    g_red = 1'b1;
    g_tgt = 32'h1c000100;
    step();
    g_red = 1'b0;
    g_dok = 1'b1;
    repeat (8) step();
    chk("redw_acc", 65'(acc_log[3]), 65'h1c000100);
    chk("redw_bus", 65'(bus_log[2][63:32]), 65'h1c000100);
    // redirect coinciding with data_ok
    do_reset();
    run_until_acc(3);
    g_red = 1'b1;
    step();
    g_red = 1'b0;
    n = acc_log.size();
    step();
    chk("redd_nacc", 65'(acc_log.size()), 65'(n + 1));
    chk("redd_acc", 65'(acc_log[n]), 65'h1c000100);
    repeat (6) step();
    chk("redd_bus", bus_log[2], {1'b0, 32'h1c000100, mem(32'h1c000100)});
    // reset asserted while waiting
    do_reset();
    run_until_acc(2);
    async_reset_check();
    do_reset();
    repeat (2) step();
    chk("rst_first", 65'(acc_log[0]), 65'h1c000000);
    // randomized traffic with periodic asynchronous resets
    g_rnd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (800) step();
      async_reset_check();
      do_reset();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
